// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache. Hits return the word in the same cycle.
// A miss refills the whole line over a req/ack handshake, then the address is looked up again.
module icache_direct #(
   parameter int unsigned LINES          = 16,
   parameter int unsigned WORDS_PER_LINE = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] Instr_address_fIF,
   input  logic        Flush,
   output logic [31:0] Instr1_2IF,
   output logic        Stall_2IF,
   output logic        Mem_Req,
   output logic [31:0] Mem_Addr,
   input  logic        Mem_Ack,
   input  logic [31:0] Mem_Data,
   output logic [31:0] Hit_Count,
   output logic [31:0] Miss_Count
);

   localparam int unsigned OB = $clog2(WORDS_PER_LINE);
   localparam int unsigned IB = $clog2(LINES);
   localparam int unsigned TB = 32 - OB - IB - 2;
   localparam logic [31:0]   LINE_MASK = 32'(WORDS_PER_LINE * 4 - 1);
   localparam logic [OB-1:0] LAST_WORD = OB'(WORDS_PER_LINE - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      REFILL    = 2'd1,
      FILL_DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [LINES-1:0] valid, valid_nxt;
   logic [31:0]      base, base_nxt;
   logic [OB-1:0]    word_cnt, word_cnt_nxt;
   logic             flush_pending, flush_pending_nxt;
   logic [31:0]      hit_cnt, miss_cnt;
   logic             data_we, tag_we, miss_start;

   logic [TB-1:0] tag_ram  [LINES];
   logic [31:0]   data_ram [LINES][WORDS_PER_LINE];

   logic [OB-1:0] offset;
   logic [IB-1:0] index;
   logic [TB-1:0] tag;
   logic [IB-1:0] fill_idx;
   logic [TB-1:0] fill_tag;
   logic          hit;

   // Lookup address fields; the refill line is identified by the latched base.
   assign offset   = Instr_address_fIF[OB+1:2];
   assign index    = Instr_address_fIF[OB+IB+1:OB+2];
   assign tag      = Instr_address_fIF[31:OB+IB+2];
   assign fill_idx = base[OB+IB+1:OB+2];
   assign fill_tag = base[31:OB+IB+2];

   assign hit        = (state == IDLE) && valid[index] && (tag_ram[index] == tag) && !Flush;
   assign Instr1_2IF = hit ? data_ram[index][offset] : 32'h0;
   assign Stall_2IF  = !hit;
   assign Mem_Req    = (state == REFILL);
   assign Mem_Addr   = Mem_Req ? (base + (32'(word_cnt) << 2)) : 32'h0;
   assign Hit_Count  = hit_cnt;
   assign Miss_Count = miss_cnt;

   // Next-state and refill control
   always_comb begin
      state_nxt         = state;
      valid_nxt         = valid;
      base_nxt          = base;
      word_cnt_nxt      = word_cnt;
      flush_pending_nxt = flush_pending;
      data_we           = 1'b0;
      tag_we            = 1'b0;
      miss_start        = 1'b0;
      case (state)
         IDLE: begin
            if (Flush) begin
               valid_nxt = '0;
            end else if (!hit) begin
               miss_start   = 1'b1;
               base_nxt     = Instr_address_fIF & ~LINE_MASK;
               word_cnt_nxt = '0;
               state_nxt    = REFILL;
            end
         end
         REFILL: begin
            // The handshake cannot be aborted; a flush only blocks validation.
            if (Flush) flush_pending_nxt = 1'b1;
            if (Mem_Ack) begin
               data_we = 1'b1;
               if (word_cnt == LAST_WORD) begin
                  tag_we              = 1'b1;
                  valid_nxt[fill_idx] = !(flush_pending || Flush);
                  state_nxt           = FILL_DONE;
               end else begin
                  word_cnt_nxt = word_cnt + OB'(1);
               end
            end
         end
         FILL_DONE: begin
            if (flush_pending) valid_nxt = '0;
            flush_pending_nxt = 1'b0;
            state_nxt         = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control state and saturating counters
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state         <= IDLE;
         valid         <= '0;
         base          <= 32'h0;
         word_cnt      <= '0;
         flush_pending <= 1'b0;
         hit_cnt       <= 32'h0;
         miss_cnt      <= 32'h0;
      end else begin
         state         <= state_nxt;
         valid         <= valid_nxt;
         base          <= base_nxt;
         word_cnt      <= word_cnt_nxt;
         flush_pending <= flush_pending_nxt;
         if (hit && (hit_cnt != 32'hFFFF_FFFF)) hit_cnt <= hit_cnt + 32'd1;
         if (miss_start && (miss_cnt != 32'hFFFF_FFFF)) miss_cnt <= miss_cnt + 32'd1;
      end
   end

   // Tag and data arrays carry no reset; valid bits gate their use.
   always_ff @(posedge CLK) begin
      if (data_we) data_ram[fill_idx][word_cnt] <= Mem_Data;
      if (tag_we) tag_ram[fill_idx] <= fill_tag;
   end

endmodule
